shift_unit_seq: RTL and testbench

Parametrised multi-cycle shift/rotate unit, the next generation of the team's single-step loadable shift register. It adds a programmable shift amount, left shift and rotate modes, and a start/busy/done handshake. Data is shifted one bit per clock, and the last bit shifted out is kept as a carry flag. It is intended as a datapath helper next to the ALU, where a sequencer issues `start` and waits for `done`.

---
 rtl/shift_unit_seq_if.sv | 26 ++
 rtl/shift_unit_seq.sv | 86 ++++++++
 tb/tb_shift_unit_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_seq_if.sv
// Handshake/data bundle between a sequencer and the multi-cycle shift unit.
interface shift_unit_seq_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  logic          ld;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          busy;
  logic          done;
  logic          cout;
  logic          zero;

  modport master (
    output ld, start, mode, amt, data_in,
    input  data_out, busy, done, cout, zero
  );

  modport slave (
    input  ld, start, mode, amt, data_in,
    output data_out, busy, done, cout, zero
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: one 1-bit step per clock, start/busy/done handshake,
// last bit shifted out kept in cout.
module shift_unit_seq #(
  parameter int           W       = 8,
  parameter int           AW      = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  shift_unit_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_ASR = 2'b01;
  localparam logic [1:0] M_LSL = 2'b10;

  state_e        state_q, state_d;
  logic [W-1:0]  data_q,  data_d;
  logic          cout_q,  cout_d;
  logic [AW-1:0] cnt_q,   cnt_d;
  logic [1:0]    mode_q,  mode_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      data_q  <= RST_VAL;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // ld wins over start; amt==0 skips SHIFT entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.ld && bus.start) state_d = (bus.amt == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == AW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    cout_d = cout_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          data_d = bus.data_in;
          cout_d = 1'b0;
        end else if (bus.start) begin
          mode_d = bus.mode;
          cnt_d  = bus.amt;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - AW'(1);
        case (mode_q)
          M_LSR: begin data_d = {1'b0, data_q[W-1:1]};         cout_d = data_q[0];   end
          M_ASR: begin data_d = {data_q[W-1], data_q[W-1:1]};  cout_d = data_q[0];   end
          M_LSL: begin data_d = {data_q[W-2:0], 1'b0};         cout_d = data_q[W-1]; end
          default: begin data_d = {data_q[0], data_q[W-1:1]};  cout_d = data_q[0];   end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == SHIFT);
    bus.done     = (state_q == DONE);
    bus.data_out = data_q;
    bus.cout     = cout_q;
    bus.zero     = (data_q == '0);
  end
endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: closed-form reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_shift_unit_seq;
  localparam int W = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  shift_unit_seq_if #(.W(W), .AW(AW)) bus ();
  shift_unit_seq #(.W(W), .AW(AW), .RST_VAL(8'h00)) dut (.clk(clk), .rst_b(rst_b), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Closed-form result of shifting d by a steps (no step-by-step iteration)
  function automatic void ref_op(input logic [W-1:0] d, input logic [1:0] m, input int a,
                                 input logic cin, output logic [W-1:0] r, output logic c);
    int k;
    r = d; c = cin;
    if (a == 0) return;
    case (m)
      2'b00: begin r = d >> a; c = (a <= W) ? d[a-1] : 1'b0; end
      2'b01: begin r = W'($signed(d) >>> a); c = (a <= W) ? d[a-1] : d[W-1]; end
      2'b10: begin r = d << a; c = (a <= W) ? d[W-a] : 1'b0; end
      default: begin
        k = a % W;
        r = (k == 0) ? d : W'((d >> k) | (d << (W - k)));
        c = d[(a-1) % W];
      end
    endcase
  endfunction

  // Transaction-level model: remaining busy cycles, done flag, final result
  int           m_left = 0;
  bit           m_done = 0;
  logic [W-1:0] m_data = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_left = 0; m_done = 0; m_data = '0; m_cout = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (bus.ld) begin
      m_data = bus.data_in; m_cout = 1'b0;
    end else if (bus.start) begin
      ref_op(m_data, bus.mode, int'(bus.amt), m_cout, m_data, m_cout);
      if (bus.amt == '0) m_done = 1;
      else m_left = int'(bus.amt);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(bus.busy), int'(m_left > 0));
      chk("done", int'(bus.done), int'(m_done));
      if (m_left == 0) begin
        chk("data_out", int'(bus.data_out), int'(m_data));
        chk("cout", int'(bus.cout), int'(m_cout));
        chk("zero", int'(bus.zero), int'(m_data == '0));
      end
    end
  end

  task automatic do_ld(input logic [W-1:0] v);
    @(negedge clk);
    bus.ld = 1'b1; bus.data_in = v;
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    bit seen = 0;
    nb = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (bus.busy) nb++;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic start_op(input logic [1:0] m, input logic [AW-1:0] a);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.amt = a;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] m, input logic [AW-1:0] a, output int nb);
    start_op(m, a);
    wait_done(nb);
  endtask

  task automatic chk_res(input string name, input logic [W-1:0] d, input logic c);
    chk({name, "_data"}, int'(bus.data_out), int'(d));
    chk({name, "_cout"}, int'(bus.cout), int'(c));
  endtask

  int nb;

  initial begin
    bus.ld = 0; bus.start = 0; bus.mode = 2'b00; bus.amt = '0; bus.data_in = '0;
    #1 rst_b = 1'b0;
    #2;
    chk("rst_data", int'(bus.data_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_zero", int'(bus.zero), 1);
    @(negedge clk); rst_b = 1'b1;
    chk_en = 1;

    // LSR by 3
    do_ld(8'b1011_0010);
    do_op(2'b00, 3'd3, nb);
    chk("lsr_busy_cycles", nb, 3);
    chk_res("lsr", 8'b0001_0110, 1'b0);

    // ASR by 3, LSL by 1
    do_ld(8'b1011_0010);
    do_op(2'b01, 3'd3, nb);
    chk_res("asr", 8'b1111_0110, 1'b0);
    do_ld(8'b1011_0010);
    do_op(2'b10, 3'd1, nb);
    chk("lsl_busy_cycles", nb, 1);
    chk_res("lsl", 8'b0110_0100, 1'b1);

    // ROR by 4
    do_ld(8'b1011_0010);
    do_op(2'b11, 3'd4, nb);
    chk_res("ror", 8'b0010_1011, 1'b0);

    // LSL by max amount
    do_ld(8'hFF);
    do_op(2'b10, 3'd7, nb);
    chk_res("lsl7", 8'h80, 1'b1);

    // Zero result then amt=0
    do_ld(8'b0000_0001);
    do_op(2'b00, 3'd1, nb);
    chk_res("lsr_to_zero", 8'h00, 1'b1);
    chk("zero_flag", int'(bus.zero), 1);
    do_op(2'b00, 3'd0, nb);
    chk("amt0_busy_cycles", nb, 0);
    chk_res("amt0", 8'h00, 1'b1);

    // ld/start/mode changes while shifting are ignored
    do_ld(8'hC5);
    start_op(2'b00, 3'd5);
    @(negedge clk); bus.ld = 1'b1; bus.data_in = 8'hFF;
    @(negedge clk); bus.ld = 1'b0; bus.start = 1'b1; bus.mode = 2'b11; bus.amt = 3'd7;
    @(negedge clk); bus.start = 1'b0;
    wait_done(nb);
    chk_res("ignored", 8'h06, 1'b0);

    // Asynchronous reset in the middle of SHIFT
    do_ld(8'hA5);
    start_op(2'b00, 3'd6);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("midrst_data", int'(bus.data_out), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_cout", int'(bus.cout), 0);
    @(negedge clk); rst_b = 1'b1;
    do_ld(8'h81);
    do_op(2'b11, 3'd1, nb);
    chk_res("post_rst_ror", 8'hC0, 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
